// File: rtl/sdram_arbit_if.sv
// SDRAM pad-side bus: command pins, clock enable and write data path.
// The arbiter drives it through the master modport. The pads or a monitor
// observe it through the slave modport.
interface sdram_arbit_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [15:0] dq_out;
    logic        dq_oe;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_out, dq_oe
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter. It sequences the init, auto-refresh, write and read
// sub-controllers, and gives the bus to one of them at a time. It registers
// the selected 18-bit command and the write data onto the pads.
module sdram_arbit #(
    parameter int unsigned GRANT_TIMEOUT = 4095,
    parameter logic [17:0] NOP_CMD       = 18'h1c000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_end,
    input  logic [17:0] init_cmd,
    input  logic        ref_req,
    input  logic [17:0] ref_cmd,
    input  logic        ref_end,
    output logic        ref_en,
    input  logic        w_req,
    input  logic [17:0] w_cmd,
    input  logic [15:0] w_dq,
    input  logic        write_data_end,
    input  logic        write_ref_break_end,
    output logic        w_en,
    input  logic        r_req,
    input  logic [17:0] r_cmd,
    input  logic        read_data_end,
    input  logic        read_ref_break_end,
    output logic        r_en,
    sdram_arbit_if.master sdram,
    output logic        err_timeout
);

    typedef enum logic [2:0] {ST_INIT, ST_ARBIT, ST_AREF, ST_WRITE, ST_READ} state_e;

    localparam logic [11:0] TIMEOUT_CNT = 12'(GRANT_TIMEOUT);

    state_e      state_q, state_d;
    logic        read_turn_q, read_turn_d;   // a write/read tie goes to read when set
    logic [11:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic        ref_en_q, ref_en_d;
    logic        w_en_q, w_en_d;
    logic        r_en_q, r_en_d;
    logic [17:0] cmd_q, cmd_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;
    logic        cke_q, cke_d;
    logic        in_grant;
    logic        timeout;

    assign in_grant = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);
    // The grant currently held reaches its GRANT_TIMEOUT-th cycle.
    assign timeout  = (GRANT_TIMEOUT != 0) && in_grant && ((wd_q + 12'd1) == TIMEOUT_CNT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, so update order does not matter.
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: refresh first, then write/read with alternation on ties.
    always_comb begin
        // NOTE: default first so that no path leaves state_d unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_INIT:  if (init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (ref_req)                             state_d = ST_AREF;
                else if (w_req && (!r_req || !read_turn_q)) state_d = ST_WRITE;
                else if (r_req)                          state_d = ST_READ;
            end
            ST_AREF:  if (ref_end) state_d = ST_ARBIT;
            ST_WRITE: if (write_data_end || write_ref_break_end) state_d = ST_ARBIT;
            ST_READ:  if (read_data_end || read_ref_break_end) state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
        if (timeout) state_d = ST_ARBIT;
    end

    // Output and datapath next values: grants, fairness, watchdog, and the command and data mux.
    always_comb begin
        ref_en_d    = (state_d == ST_AREF)  && (state_q != ST_AREF);
        w_en_d      = (state_d == ST_WRITE) && (state_q != ST_WRITE);
        r_en_d      = (state_d == ST_READ)  && (state_q != ST_READ);

        read_turn_d = read_turn_q;
        if (w_en_d) read_turn_d = 1'b1;
        if (r_en_d) read_turn_d = 1'b0;

        if (state_d != state_q) wd_d = '0;
        else if (in_grant)      wd_d = wd_q + 12'd1;
        else                    wd_d = wd_q;

        err_d    = err_q | timeout;
        cke_d    = 1'b1;
        cmd_d    = NOP_CMD;
        dq_out_d = dq_out_q;
        dq_oe_d  = 1'b0;
        if (!timeout) begin
            unique case (state_q)
                ST_INIT:  cmd_d = init_cmd;
                ST_AREF:  cmd_d = ref_cmd;
                ST_WRITE: begin
                    cmd_d    = w_cmd;
                    dq_out_d = w_dq;
                    dq_oe_d  = 1'b1;
                end
                ST_READ:  cmd_d = r_cmd;
                default:  cmd_d = NOP_CMD;
            endcase
        end
    end

    // Output and datapath registers. Reset puts NOP on the pins and drops every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_turn_q <= 1'b0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            ref_en_q    <= 1'b0;
            w_en_q      <= 1'b0;
            r_en_q      <= 1'b0;
            cmd_q       <= NOP_CMD;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            cke_q       <= 1'b0;
        end else begin
            read_turn_q <= read_turn_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            ref_en_q    <= ref_en_d;
            w_en_q      <= w_en_d;
            r_en_q      <= r_en_d;
            cmd_q       <= cmd_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            cke_q       <= cke_d;
        end
    end

    assign ref_en       = ref_en_q;
    assign w_en         = w_en_q;
    assign r_en         = r_en_q;
    assign err_timeout  = err_q;
    assign sdram.cke    = cke_q;
    assign sdram.cs_n   = cmd_q[17];
    assign sdram.ras_n  = cmd_q[16];
    assign sdram.cas_n  = cmd_q[15];
    assign sdram.we_n   = cmd_q[14];
    assign sdram.ba     = cmd_q[13:12];
    assign sdram.addr   = cmd_q[11:0];
    assign sdram.dq_out = dq_out_q;
    assign sdram.dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit. The stimulus side runs a bus-ownership
// reference model and queues the pad and grant values due after each clock
// edge. A monitor pops one entry per edge and compares.
module tb_sdram_arbit;

    localparam int          TMO = 16;
    localparam logic [17:0] NOP = 18'h1c000;
    localparam logic [17:0] PALL = 18'h08400;
    localparam logic [17:0] ACT_ROW5 = 18'h0c005;

    typedef enum {O_INIT, O_IDLE, O_REF, O_WR, O_RD} owner_e;
    typedef enum {LAST_NONE, LAST_WR, LAST_RD} last_e;

    typedef struct {
        logic [17:0] cmd;
        logic [15:0] dq;
        logic        oe;
        logic        cke;
        logic        ref_en;
        logic        w_en;
        logic        r_en;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end, ref_req, ref_end, w_req, r_req;
    logic        write_data_end, write_ref_break_end, read_data_end, read_ref_break_end;
    logic [17:0] init_cmd, ref_cmd, w_cmd, r_cmd;
    logic [15:0] w_dq;
    logic        ref_en, w_en, r_en, err_timeout;

    sdram_arbit_if sd ();

    sdram_arbit #(.GRANT_TIMEOUT(TMO), .NOP_CMD(NOP)) dut (
        .clk(clk), .rst(rst),
        .init_end(init_end), .init_cmd(init_cmd),
        .ref_req(ref_req), .ref_cmd(ref_cmd), .ref_end(ref_end), .ref_en(ref_en),
        .w_req(w_req), .w_cmd(w_cmd), .w_dq(w_dq),
        .write_data_end(write_data_end), .write_ref_break_end(write_ref_break_end), .w_en(w_en),
        .r_req(r_req), .r_cmd(r_cmd),
        .read_data_end(read_data_end), .read_ref_break_end(read_ref_break_end), .r_en(r_en),
        .sdram(sd), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int     n_total = 0;
    int     n_bad   = 0;
    exp_t   sb_q[$];

    // Reference model state: who owns the bus, who won the last write/read grant, and how long the grant has lasted.
    owner_e      m_owner = O_INIT;
    last_e       m_last  = LAST_NONE;
    int          m_age   = 0;
    logic        m_err   = 1'b0;
    logic [15:0] m_dq    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
        end
    endtask

    function automatic bool_grant(owner_e o);
        return (o == O_REF) || (o == O_WR) || (o == O_RD);
    endfunction

    // Apply one clock of the ownership rules to the current inputs and queue what the pads must show afterwards.
    task automatic model_step();
        exp_t   e;
        owner_e nxt;
        bit     to;
        if (rst) begin
            e = '{cmd: NOP, dq: 16'h0, oe: 1'b0, cke: 1'b0, ref_en: 1'b0, w_en: 1'b0, r_en: 1'b0, err: 1'b0};
            m_owner = O_INIT; m_last = LAST_NONE; m_age = 0; m_err = 1'b0; m_dq = '0;
        end else begin
            to = bool_grant(m_owner) && (m_age == TMO);
            e.cke = 1'b1;
            e.oe  = 1'b0;
            e.cmd = NOP;
            if (!to) begin
                case (m_owner)
                    O_INIT: e.cmd = init_cmd;
                    O_REF:  e.cmd = ref_cmd;
                    O_WR:   begin e.cmd = w_cmd; m_dq = w_dq; e.oe = 1'b1; end
                    O_RD:   e.cmd = r_cmd;
                    default: e.cmd = NOP;
                endcase
            end
            e.dq = m_dq;
            nxt = m_owner;
            if (to) nxt = O_IDLE;
            else case (m_owner)
                O_INIT: if (init_end) nxt = O_IDLE;
                O_IDLE: begin
                    if (ref_req)             nxt = O_REF;
                    else if (w_req && r_req) nxt = (m_last == LAST_WR) ? O_RD : O_WR;
                    else if (w_req)          nxt = O_WR;
                    else if (r_req)          nxt = O_RD;
                end
                O_REF: if (ref_end) nxt = O_IDLE;
                O_WR:  if (write_data_end || write_ref_break_end) nxt = O_IDLE;
                O_RD:  if (read_data_end || read_ref_break_end) nxt = O_IDLE;
                default: nxt = O_INIT;
            endcase
            e.ref_en = (nxt == O_REF) && (m_owner != O_REF);
            e.w_en   = (nxt == O_WR)  && (m_owner != O_WR);
            e.r_en   = (nxt == O_RD)  && (m_owner != O_RD);
            if (e.w_en) m_last = LAST_WR;
            if (e.r_en) m_last = LAST_RD;
            if (nxt != m_owner) m_age = bool_grant(nxt) ? 1 : 0;
            else if (bool_grant(nxt)) m_age++;
            m_err = m_err | to;
            e.err = m_err;
            m_owner = nxt;
        end
        sb_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        write_data_end = 0; write_ref_break_end = 0;
        read_data_end = 0; read_ref_break_end = 0; ref_end = 0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare the pads and grants against the scoreboard one time unit after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cmd", 32'({sd.cs_n, sd.ras_n, sd.cas_n, sd.we_n, sd.ba, sd.addr}), 32'(e.cmd));
                check("dq_out", 32'(sd.dq_out), 32'(e.dq));
                check("dq_oe", 32'(sd.dq_oe), 32'(e.oe));
                check("cke", 32'(sd.cke), 32'(e.cke));
                check("grants", {29'd0, ref_en, w_en, r_en}, {29'd0, e.ref_en, e.w_en, e.r_en});
                check("err_timeout", 32'(err_timeout), 32'(e.err));
            end
        end
    end

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            init_end = ($urandom_range(0, 7) == 0);
            if (m_owner == O_REF) ref_req = 0;
            else if (!ref_req && $urandom_range(0, 15) == 0) ref_req = 1;
            if ($urandom_range(0, 7) == 0) w_req = ~w_req;
            if ($urandom_range(0, 7) == 0) r_req = ~r_req;
            ref_end             = ($urandom_range(0, 4) == 0);
            write_data_end      = ($urandom_range(0, 5) == 0);
            write_ref_break_end = ($urandom_range(0, 9) == 0);
            read_data_end       = ($urandom_range(0, 5) == 0);
            read_ref_break_end  = ($urandom_range(0, 9) == 0);
            init_cmd = 18'($urandom); ref_cmd = 18'($urandom);
            w_cmd    = 18'($urandom); r_cmd   = 18'($urandom);
            w_dq     = 16'($urandom);
            tick();
        end
    endtask

    initial begin
        rst = 1; init_end = 0; ref_req = 0; ref_end = 0; w_req = 0; r_req = 0;
        write_data_end = 0; write_ref_break_end = 0; read_data_end = 0; read_ref_break_end = 0;
        init_cmd = NOP; ref_cmd = NOP; w_cmd = NOP; r_cmd = NOP; w_dq = '0;
        hold(3);
        rst = 0;

        // Init sequence: PALL toggling on the init command, init_end on cycle 10.
        for (int c = 0; c <= 10; c++) begin
            init_cmd = c[1] ? PALL : NOP;
            init_end = (c == 10);
            tick();
        end
        init_end = 0;
        init_cmd = NOP;
        hold(2);

        // All three requests together: refresh, then write, then read.
        ref_cmd = 18'h04400; w_cmd = 18'h1c0aa; r_cmd = 18'h0a123;
        ref_req = 1; w_req = 1; r_req = 1;
        tick();
        ref_req = 0;
        hold(3);
        ref_end = 1;
        tick();
        hold(2);
        // Row 5 activate with write data while holding the write grant.
        w_cmd = ACT_ROW5; w_dq = 16'hA55A;
        hold(2);
        write_data_end = 1;
        tick();
        hold(3);
        read_data_end = 1;
        r_req = 0;
        tick();
        hold(2);

        // A write breaks for refresh and is then granted again.
        w_req = 0;
        hold(3);
        w_req = 1;
        hold(3);
        ref_req = 1;
        write_ref_break_end = 1;
        tick();
        hold(2);
        ref_req = 0;
        hold(2);
        ref_end = 1;
        tick();
        hold(4);

        // Reset in the middle of a write, then init again.
        rst = 1;
        tick();
        rst = 0;
        hold(2);
        init_end = 1;
        tick();
        init_end = 0;

        // Watchdog: a write grant with no end strobe.
        w_req = 1; r_req = 0;
        hold(TMO + 6);
        w_req = 0;
        hold(4);

        random_phase(800);
        rst = 1;
        hold(2);
        rst = 0;
        random_phase(800);

        rst = 0;
        hold(2);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
